// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a word-only MIPS data-memory port.
// Accepts load/store requests over valid/ready, converts byte addresses to
// word indices, and uses read-modify-write for byte/halfword stores.
// Optional build macro: LSU_ALIGN_CHECK_EN
//   defined   -> illegal size, misaligned and out-of-range requests are
//                answered with rsp_error and touch no memory.
//   undefined -> rsp_error is tied low, misaligned low bits are dropped,
//                the word index wraps modulo DEPTH_WORDS and size 11 is a word.
module load_store_unit #(
    parameter int DEPTH_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] Adress,
    output logic [31:0] Write_Data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] Read_Data
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of a memory word with new store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    state_t      state_q,       state_d;
    logic        write_q,       write_d;
    logic [1:0]  size_q,        size_d;
    logic        uns_q,         uns_d;
    logic [1:0]  lane_q,        lane_d;
    logic [31:0] wdata_q,       wdata_d;
    logic        err_q,         err_d;
    logic [31:0] adress_q,      adress_d;
    logic [31:0] write_data_q,  write_data_d;
    logic [31:0] rsp_rdata_q,   rsp_rdata_d;

    logic        accept_s;
    logic        err_s;
    logic [1:0]  eff_size_s;
    logic [1:0]  lane_s;
    logic [31:0] word_idx_s;

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign accept_s   = req_valid && req_ready;
    assign word_idx_s = {{(32 - AW){1'b0}}, req_addr[AW + 1:2]};

`ifndef LSU_ALIGN_CHECK_EN
    logic unused_addr_s;
    assign unused_addr_s = ^req_addr[31:AW + 2];
`endif

    // Classify the incoming request: effective size, lane and error flag.
    always_comb begin
        err_s      = 1'b0;
        eff_size_s = req_size;
        lane_s     = req_addr[1:0];
`ifdef LSU_ALIGN_CHECK_EN
        if ((req_size == 2'b11) ||
            ((req_size == SZ_HALF) && req_addr[0]) ||
            ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
            (|req_addr[31:AW + 2])) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
`else
        case (req_size)
            SZ_BYTE: begin
                eff_size_s = SZ_BYTE;
                lane_s     = req_addr[1:0];
            end
            SZ_HALF: begin
                eff_size_s = SZ_HALF;
                lane_s     = {req_addr[1], 1'b0};
            end
            default: begin
                eff_size_s = SZ_WORD;
                lane_s     = 2'b00;
            end
        endcase
`endif
    end

    // Next-state and datapath update for the request sequencer.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        adress_d     = adress_q;
        write_data_d = write_data_q;
        rsp_rdata_d  = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    write_d     = req_write;
                    size_d      = eff_size_s;
                    uns_d       = req_unsigned;
                    lane_d      = lane_s;
                    wdata_d     = req_wdata;
                    err_d       = err_s;
                    rsp_rdata_d = 32'd0;
                    if (err_s) begin
                        state_d = S_RESP;
                    end else if (req_write && (eff_size_s == SZ_WORD)) begin
                        adress_d     = word_idx_s;
                        write_data_d = req_wdata;
                        state_d      = S_WR;
                    end else begin
                        adress_d = word_idx_s;
                        state_d  = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (write_q) begin
                    write_data_d = store_merge(Read_Data, wdata_q, size_q, lane_q);
                    state_d      = S_WR;
                end else begin
                    rsp_rdata_d = load_extract(Read_Data, size_q, lane_q, uns_q);
                    state_d     = S_RESP;
                end
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            adress_q     <= 32'd0;
            write_data_q <= 32'd0;
            rsp_rdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            adress_q     <= adress_d;
            write_data_q <= write_data_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Strobes and response come straight from state; reset kills them at once
    // so an interrupted read-modify-write never commits.
    assign MemRead    = (state_q == S_RD) && !reset;
    assign MemWrite   = (state_q == S_WR) && !reset;
    assign rsp_valid  = (state_q == S_RESP) && !reset;
    assign rsp_error  = rsp_valid && err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign Adress     = adress_q;
    assign Write_Data = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit against a 32-word
// combinational memory model with word 1 preloaded to 0x8899AABB.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] Adress;
    logic [31:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_Data;

    logic [31:0] mem [0:31];
    logic        mem_init;

    int n_checks = 0;
    int n_pass   = 0;

    int          res_lat;
    int          res_rd;
    int          res_wr;
    int          res_both;
    int          res_ready_bad;
    logic        res_done;
    logic        res_err;
    logic [31:0] res_rdata;
    logic [31:0] res_addr;
    logic [31:0] res_wdata;

    load_store_unit #(.DEPTH_WORDS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .Adress       (Adress),
        .Write_Data   (Write_Data),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .Read_Data    (Read_Data)
    );

    always #5 clk = ~clk;

    assign Read_Data = mem[Adress[4:0]];

    // Memory model: preload on mem_init, otherwise commit strobed writes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 32'd0;
            end
            mem[1] <= 32'h8899AABB;
        end else if (MemWrite) begin
            mem[Adress[4:0]] <= Write_Data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and observe it until its response pulse.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        res_lat = 0; res_rd = 0; res_wr = 0; res_both = 0; res_ready_bad = 0;
        res_done = 1'b0; res_err = 1'b0; res_rdata = 32'hX;
        res_addr = 32'hX; res_wdata = 32'hX;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        if (!req_ready) res_ready_bad++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 8 && !res_done; cyc++) begin
            @(negedge clk);
            if (MemRead && MemWrite) res_both++;
            if (MemRead) begin
                res_rd++;
                res_addr = Adress;
            end
            if (MemWrite) begin
                res_wr++;
                res_addr  = Adress;
                res_wdata = Write_Data;
            end
            if (req_ready) res_ready_bad++;
            if (rsp_valid) begin
                res_done  = 1'b1;
                res_lat   = cyc;
                res_rdata = rsp_rdata;
                res_err   = rsp_error;
            end
        end
        @(negedge clk);
        if (!req_ready) res_ready_bad++;
    endtask

    // Compare the recorded transaction against hand-computed expectations.
    task automatic expect_txn(input string tag, input int lat, input logic [31:0] rdata,
                              input logic err, input int rd, input int wr);
        check_eq({tag, "_done"},  {31'd0, res_done}, 32'd1);
        check_eq({tag, "_lat"},   res_lat, lat);
        check_eq({tag, "_rdata"}, res_rdata, rdata);
        check_eq({tag, "_err"},   {31'd0, res_err}, {31'd0, err});
        check_eq({tag, "_rd"},    res_rd, rd);
        check_eq({tag, "_wr"},    res_wr, wr);
        check_eq({tag, "_both"},  res_both, 32'd0);
        check_eq({tag, "_ready"}, res_ready_bad, 32'd0);
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready",   {31'd0, req_ready}, 32'd0);
        check_eq("rst_rsp_v",   {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_e",   {31'd0, rsp_error}, 32'd0);
        check_eq("rst_memrd",   {31'd0, MemRead},   32'd0);
        check_eq("rst_memwr",   {31'd0, MemWrite},  32'd0);
        check_eq("rst_rdata",   rsp_rdata,  32'd0);
        check_eq("rst_adress",  Adress,     32'd0);
        check_eq("rst_wdata",   Write_Data, 32'd0);
        reset = 1'b0; mem_init = 1'b0;
        #1;
        check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Word load from word 1.
        run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'd0);
        expect_txn("lw4", 2, 32'h8899AABB, 1'b0, 1, 0);
        check_eq("lw4_adress", res_addr, 32'd1);

        // Sub-word loads, signed and unsigned, all lanes of interest.
        run_req(1'b0, 2'b00, 1'b0, 32'h7, 32'd0);
        expect_txn("lb7", 2, 32'hFFFFFF88, 1'b0, 1, 0);
        run_req(1'b0, 2'b01, 1'b1, 32'h4, 32'd0);
        expect_txn("lhu4", 2, 32'h0000AABB, 1'b0, 1, 0);
        run_req(1'b0, 2'b01, 1'b0, 32'h6, 32'd0);
        expect_txn("lh6", 2, 32'hFFFF8899, 1'b0, 1, 0);
        run_req(1'b0, 2'b00, 1'b1, 32'h5, 32'd0);
        expect_txn("lbu5", 2, 32'h000000AA, 1'b0, 1, 0);

`ifdef LSU_ALIGN_CHECK_EN
        run_req(1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
        expect_txn("err_mis_w", 1, 32'd0, 1'b1, 0, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h80, 32'd0);
        expect_txn("err_range", 1, 32'd0, 1'b1, 0, 0);
        run_req(1'b0, 2'b11, 1'b0, 32'h4, 32'd0);
        expect_txn("err_size", 1, 32'd0, 1'b1, 0, 0);
        run_req(1'b0, 2'b01, 1'b0, 32'h5, 32'd0);
        expect_txn("err_mis_h", 1, 32'd0, 1'b1, 0, 0);
        run_req(1'b1, 2'b10, 1'b0, 32'h2, 32'h12345678);
        expect_txn("err_st", 1, 32'd0, 1'b1, 0, 0);
        check_eq("err_st_mem0", mem[0], 32'd0);
`else
        run_req(1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
        expect_txn("mis_w", 2, 32'h8899AABB, 1'b0, 1, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h84, 32'd0);
        expect_txn("wrap", 2, 32'h8899AABB, 1'b0, 1, 0);
        check_eq("wrap_adress", res_addr, 32'd1);
        run_req(1'b0, 2'b11, 1'b0, 32'h4, 32'd0);
        expect_txn("size3", 2, 32'h8899AABB, 1'b0, 1, 0);
        run_req(1'b0, 2'b01, 1'b0, 32'h5, 32'd0);
        expect_txn("mis_h", 2, 32'hFFFFAABB, 1'b0, 1, 0);
`endif

        // Byte store by read-modify-write, then read it back.
        run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h00000011);
        expect_txn("sb5", 3, 32'd0, 1'b0, 1, 1);
        check_eq("sb5_adress", res_addr, 32'd1);
        check_eq("sb5_wdata",  res_wdata, 32'h889911BB);
        run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'd0);
        expect_txn("sb5_rb", 2, 32'h889911BB, 1'b0, 1, 0);

        // Word store: single write cycle, no read.
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        expect_txn("sw10", 2, 32'd0, 1'b0, 0, 1);
        check_eq("sw10_adress", res_addr, 32'd4);
        check_eq("sw10_wdata",  res_wdata, 32'hDEADBEEF);

        // Upper halfword store into the same word.
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
        expect_txn("sh12", 3, 32'd0, 1'b0, 1, 1);
        check_eq("sh12_wdata", res_wdata, 32'h1234BEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        expect_txn("sh12_rb", 2, 32'h1234BEEF, 1'b0, 1, 0);

        // Reset during the write cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h5; req_wdata = 32'h00000022;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstwr_rd", {31'd0, MemRead}, 32'd1);
        @(negedge clk);
        check_eq("rstwr_wr_pre", {31'd0, MemWrite}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rstwr_wr_gated", {31'd0, MemWrite}, 32'd0);
        check_eq("rstwr_rd_gated", {31'd0, MemRead},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rstwr_rsp_v", {31'd0, rsp_valid}, 32'd0);
        check_eq("rstwr_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rstwr_mem1",  mem[1], 32'h889911BB);
        @(negedge clk);
        check_eq("rstwr_rsp_v2", {31'd0, rsp_valid}, 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'd0);
        expect_txn("rstwr_rb", 2, 32'h889911BB, 1'b0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
